iface_byte_fifo: RTL

- Small first-word-fall-through byte FIFO with a valid/ready handshake.
- Sits directly downstream of the 8-bit data interface bundle (`data`, `clk`) used in the interface-instantiation tests. It consumes bytes written through that bundle and presents them, in order, to a consumer stage.
- Decouples the producer's write timing from the consumer, and adds the occupancy and flush controls the interface tests need to check ordering and back-pressure.

---
 rtl/iface_byte_fifo.sv | 68 ++++++
 1 files changed

// File: rtl/iface_byte_fifo.sv
// First-word-fall-through FIFO placed behind the 8-bit data interface bundle.
// Pointers and occupancy reset asynchronously; storage is never cleared.
module iface_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Readiness comes only from the registered count, so out_ready never reaches in_ready.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Flush outranks any push or pop arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
